// File: rtl/ecc_hamming_scrubber.sv
// Background scrubber for a 12-bit Hamming-SEC codeword memory (8 data + 4 check bits).
// Uses idle memory-port cycles to read each word, write back single-bit corrections and flag uncorrectable words.
module ecc_hamming_scrubber #(
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int INTERVAL = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              scrub_en_i,
  input  logic              host_req_i,
  input  logic              host_wr_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [11:0]       mem_wdata_o,
  input  logic [11:0]       mem_rdata_i,
  input  logic              clear_stats_i,
  output logic [7:0]        corrected_cnt_o,
  output logic              uncorr_flag_o,
  output logic [ADDR_W-1:0] uncorr_addr_o,
  output logic              pass_done_o
);

  localparam int TMR_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  // Code bits covered by each syndrome bit (Hamming positions with bit k set).
  localparam logic [11:0] MASK0 = 12'h555;
  localparam logic [11:0] MASK1 = 12'h666;
  localparam logic [11:0] MASK2 = 12'h878;
  localparam logic [11:0] MASK3 = 12'hF80;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WB
  } state_e;

  state_e            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [ADDR_W-1:0] addr_q;
  logic [11:0]       corr_q;
  logic [7:0]        cnt_q;
  logic              flag_q;
  logic [ADDR_W-1:0] uaddr_q;
  logic              pass_q;

  logic [3:0]        syn_d;
  logic [11:0]       corr_d;
  logic              correctable_d;
  logic              uncorrectable_d;
  logic              collide_d;
  logic              last_d;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    syn_d = {^(mem_rdata_i & MASK3), ^(mem_rdata_i & MASK2),
             ^(mem_rdata_i & MASK1), ^(mem_rdata_i & MASK0)};
    correctable_d   = (syn_d != 4'd0) && (syn_d <= 4'd12);
    uncorrectable_d = (syn_d > 4'd12);
    corr_d = mem_rdata_i;
    if (correctable_d) begin
      corr_d = mem_rdata_i ^ (12'd1 << (syn_d - 4'd1));
    end
    // A host write to the word being scrubbed makes our read stale.
    collide_d = host_req_i & host_wr_i & (host_addr_i == addr_q);
    last_d    = (addr_q == ADDR_LAST);
    addr_d    = last_d ? '0 : addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      corr_q  <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      uaddr_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      pass_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!scrub_en_i) begin
            timer_q <= '0;
          end else if (timer_q == TMR_LAST) begin
            timer_q <= '0;
            state_q <= S_RD;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_RD: begin
          if (!host_req_i) state_q <= S_CAP;
        end
        S_CAP: begin
          if (uncorrectable_d) begin
            flag_q  <= 1'b1;
            uaddr_q <= addr_q;
          end
          if (correctable_d && !collide_d) begin
            corr_q  <= corr_d;
            state_q <= S_WB;
          end else begin
            addr_q  <= addr_d;
            pass_q  <= last_d;
            state_q <= S_IDLE;
          end
        end
        S_WB: begin
          if (collide_d) begin
            addr_q  <= addr_d;
            pass_q  <= last_d;
            state_q <= S_IDLE;
          end else if (!host_req_i) begin
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            addr_q  <= addr_d;
            pass_q  <= last_d;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (clear_stats_i) begin
        cnt_q   <= '0;
        flag_q  <= 1'b0;
        uaddr_q <= '0;
      end
    end
  end

  // Strobes yield to the host within the same cycle.
  assign mem_rd_en_o     = (state_q == S_RD) & ~host_req_i;
  assign mem_wr_en_o     = (state_q == S_WB) & ~host_req_i;
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = corr_q;
  assign corrected_cnt_o = cnt_q;
  assign uncorr_flag_o   = flag_q;
  assign uncorr_addr_o   = uaddr_q;
  assign pass_done_o     = pass_q;

endmodule

// File: tb/tb_ecc_hamming_scrubber.sv
// Directed bench for ecc_hamming_scrubber with INTERVAL=4 and a small read-only memory model.
// Expected codewords are hand-encoded: 0xA5 -> 0xA27; errored variants 0xA67, 0x802, 0x801, 0x800.
module tb_ecc_hamming_scrubber;

  logic        clk;
  logic        rst_n;
  logic        scrub_en;
  logic        host_req;
  logic        host_wr;
  logic [3:0]  host_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [3:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic        clear_stats;
  logic [7:0]  corrected_cnt;
  logic        uncorr_flag;
  logic [3:0]  uncorr_addr;
  logic        pass_done;

  int checks = 0;
  int fails  = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int pass_cnt = 0;
  int viol   = 0;

  logic [11:0] mem [16];

  ecc_hamming_scrubber #(.ADDR_W(4), .DEPTH(16), .INTERVAL(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .scrub_en_i     (scrub_en),
    .host_req_i     (host_req),
    .host_wr_i      (host_wr),
    .host_addr_i    (host_addr),
    .mem_rd_en_o    (mem_rd_en),
    .mem_wr_en_o    (mem_wr_en),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .clear_stats_i  (clear_stats),
    .corrected_cnt_o(corrected_cnt),
    .uncorr_flag_o  (uncorr_flag),
    .uncorr_addr_o  (uncorr_addr),
    .pass_done_o    (pass_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data appears the cycle after the strobe; stored words only change under bench control.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    #4;
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) wr_cnt++;
    if (pass_done) pass_cnt++;
    if ((mem_rd_en || mem_wr_en) && host_req) viol++;
    if (mem_rd_en && mem_wr_en) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_rd_en && n < 40);
    if (!mem_rd_en) chk("rd_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_rd_addr(input logic [3:0] a);
    int n;
    int k;
    k = 0;
    do begin
      wait_rd(n);
      k++;
    end while (mem_addr != a && k < 20);
    chk("rd_addr", 32'(mem_addr), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int snap;
    rst_n = 1'b0;
    scrub_en = 1'b0;
    host_req = 1'b0;
    host_wr = 1'b0;
    host_addr = 4'd0;
    clear_stats = 1'b0;
    mem_rdata = 12'h000;
    for (int i = 0; i < 16; i++) mem[i] = 12'hA27;
    repeat (3) @(negedge clk);
    chk("rst_rd", 32'(mem_rd_en), 32'd0);
    chk("rst_wr", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_cnt", 32'(corrected_cnt), 32'd0);
    chk("rst_flag", 32'(uncorr_flag), 32'd0);
    chk("rst_pass", 32'(pass_done), 32'd0);
    rst_n = 1'b1;
    scrub_en = 1'b1;

    // Clean pass: first read after INTERVAL idle cycles, then one every 6 cycles.
    wait_rd(n);
    chk("first_rd_lat", 32'(n), 32'd4);
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      wait_rd(n);
      if (n != 6) bad++;
    end
    chk("rd_period", 32'(bad), 32'd0);
    chk("last_addr", 32'(mem_addr), 32'd15);
    @(negedge clk);
    @(negedge clk);
    chk("pass_pulse", 32'(pass_done), 32'd1);
    chk("wrap_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    chk("pass_once", 32'(pass_cnt), 32'd1);
    chk("clean_no_wr", 32'(wr_cnt), 32'd0);

    mem[5]  = 12'hA67;
    mem[9]  = 12'h802;
    mem[10] = 12'h801;
    mem[11] = 12'h800;
    mem[14] = 12'hA67;
    mem[15] = 12'hA67;

    // Single-bit error at addr 5.
    wait_rd_addr(4'd5);
    @(negedge clk);
    chk("wb_not_early", 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    chk("wb5_en", 32'(mem_wr_en), 32'd1);
    chk("wb5_addr", 32'(mem_addr), 32'd5);
    chk("wb5_data", 32'(mem_wdata), 32'hA27);
    @(negedge clk);
    chk("cnt_1", 32'(corrected_cnt), 32'd1);

    // Syndrome 14 at addr 9, then clear.
    wait_rd_addr(4'd9);
    @(negedge clk);
    @(negedge clk);
    chk("unc9_no_wr", 32'(mem_wr_en), 32'd0);
    chk("unc9_flag", 32'(uncorr_flag), 32'd1);
    chk("unc9_addr", 32'(uncorr_addr), 32'd9);
    chk("unc9_adv", 32'(mem_addr), 32'd10);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk("clr_flag", 32'(uncorr_flag), 32'd0);
    chk("clr_uaddr", 32'(uncorr_addr), 32'd0);
    chk("clr_cnt", 32'(corrected_cnt), 32'd0);

    // Boundary syndromes: 13 uncorrectable, 12 correctable.
    wait_rd_addr(4'd10);
    @(negedge clk);
    @(negedge clk);
    chk("unc10_flag", 32'(uncorr_flag), 32'd1);
    chk("unc10_addr", 32'(uncorr_addr), 32'd10);
    wait_rd_addr(4'd11);
    @(negedge clk);
    @(negedge clk);
    chk("wb11_en", 32'(mem_wr_en), 32'd1);
    chk("wb11_data", 32'(mem_wdata), 32'h000);
    @(negedge clk);
    chk("cnt_after11", 32'(corrected_cnt), 32'd1);

    // Host holds the port for 3 cycles during RD of addr 13.
    wait_rd_addr(4'd12);
    repeat (5) @(negedge clk);
    host_req = 1'b1;
    @(negedge clk);
    chk("rd13_blk0", 32'(mem_rd_en), 32'd0);
    chk("rd13_addr", 32'(mem_addr), 32'd13);
    @(negedge clk);
    chk("rd13_blk1", 32'(mem_rd_en), 32'd0);
    @(negedge clk);
    chk("rd13_blk2", 32'(mem_rd_en), 32'd0);
    host_req = 1'b0;
    #1;
    chk("rd13_free", 32'(mem_rd_en), 32'd1);

    // Host read holds the port during WB of addr 14.
    wait_rd(n);
    chk("rd14_addr", 32'(mem_addr), 32'd14);
    @(negedge clk);
    host_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wb14_blk", 32'(mem_wr_en), 32'd0);
    end
    host_req = 1'b0;
    #1;
    chk("wb14_free", 32'(mem_wr_en), 32'd1);
    chk("wb14_data", 32'(mem_wdata), 32'hA27);
    @(negedge clk);
    chk("cnt_after14", 32'(corrected_cnt), 32'd2);

    // Host write to addr 15 during its WB drops the write-back.
    wait_rd(n);
    chk("rd15_addr", 32'(mem_addr), 32'd15);
    @(negedge clk);
    @(negedge clk);
    chk("wb15_en", 32'(mem_wr_en), 32'd1);
    host_req = 1'b1;
    host_wr = 1'b1;
    host_addr = 4'd15;
    #1;
    chk("wb15_yield", 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    host_req = 1'b0;
    host_wr = 1'b0;
    chk("coll_cnt", 32'(corrected_cnt), 32'd2);
    chk("coll_addr", 32'(mem_addr), 32'd0);
    chk("coll_pass", 32'(pass_done), 32'd1);
    chk("coll_no_wb", 32'(mem_wr_en), 32'd0);

    // 300 correctable steps saturate the counter.
    for (int i = 0; i < 16; i++) mem[i] = 12'hA67;
    for (int i = 0; i < 300; i++) wait_rd(n);
    repeat (3) @(negedge clk);
    chk("cnt_sat", 32'(corrected_cnt), 32'd255);

    // Async reset in the middle of a write-back.
    wait_rd(n);
    @(negedge clk);
    @(negedge clk);
    chk("wb_pre_rst", 32'(mem_wr_en), 32'd1);
    #1;
    rst_n = 1'b0;
    scrub_en = 1'b0;
    #1;
    chk("rst_wr_drop", 32'(mem_wr_en), 32'd0);
    chk("rst_rd_drop", 32'(mem_rd_en), 32'd0);
    chk("rst_cnt_clr", 32'(corrected_cnt), 32'd0);
    chk("rst_flag_clr", 32'(uncorr_flag), 32'd0);
    chk("rst_addr_clr", 32'(mem_addr), 32'd0);
    chk("rst_wdata_clr", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    scrub_en = 1'b1;

    // Disable mid-step: the step finishes, then the FSM parks in IDLE.
    wait_rd(n);
    chk("post_rst_lat", 32'(n), 32'd4);
    chk("post_rst_addr", 32'(mem_addr), 32'd0);
    scrub_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("dis_wb", 32'(mem_wr_en), 32'd1);
    @(negedge clk);
    chk("dis_addr", 32'(mem_addr), 32'd1);
    chk("dis_cnt", 32'(corrected_cnt), 32'd1);
    snap = rd_cnt;
    repeat (20) @(negedge clk);
    chk("dis_hold", 32'(rd_cnt), 32'(snap));
    chk("strobe_rules", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
